// File: rtl/demux_pkg.sv
// Shared constants and types for the 1-to-8 demultiplexer tree.
// Output indices map a select value directly to its output port (0 -> A .. 7 -> H).
package demux_pkg;
   localparam int NUM_OUT = 8;
   localparam int SEL_W   = 3;

   typedef logic [SEL_W-1:0] sel_t;

   localparam int OUT_A = 0;
   localparam int OUT_B = 1;
   localparam int OUT_C = 2;
   localparam int OUT_D = 3;
   localparam int OUT_E = 4;
   localparam int OUT_F = 5;
   localparam int OUT_G = 6;
   localparam int OUT_H = 7;
endpackage

// File: rtl/demux_1x2.sv
// Combinational 1-to-2 demultiplexer leaf: S=0 routes I to A, S=1 routes I to B.
// The unselected side is driven to zero.
module demux_1x2
   import demux_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] I,
   input  logic             S,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B
);
   assign A = S ? '0 : I;
   assign B = S ? I  : '0;
endmodule

// File: rtl/demux_1x8.sv
// 1-to-8 demultiplexer built as a three-level tree of 1-to-2 stages, with an
// optional synchronous-reset output register selected by REG_OUT.
module demux_1x8
   import demux_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter bit REG_OUT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] I,
   input  sel_t             S,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] E,
   output logic [WIDTH-1:0] F,
   output logic [WIDTH-1:0] G,
   output logic [WIDTH-1:0] H
);
   logic [WIDTH-1:0] root;
   logic [WIDTH-1:0] lvl1 [2];
   logic [WIDTH-1:0] lvl2 [4];
   logic [WIDTH-1:0] leaf [NUM_OUT];
   logic [WIDTH-1:0] q    [NUM_OUT];

   // Gating at the root means a disabled demux pushes zeros down every branch.
   assign root = en ? I : '0;

   demux_1x2 #(.WIDTH(WIDTH)) u_lvl1 (
      .I(root), .S(S[2]), .A(lvl1[0]), .B(lvl1[1])
   );

   for (genvar g = 0; g < 2; g++) begin : g_lvl2
      demux_1x2 #(.WIDTH(WIDTH)) u_dmx (
         .I(lvl1[g]), .S(S[1]), .A(lvl2[2*g]), .B(lvl2[2*g+1])
      );
   end

   for (genvar g = 0; g < 4; g++) begin : g_lvl3
      demux_1x2 #(.WIDTH(WIDTH)) u_dmx (
         .I(lvl2[g]), .S(S[0]), .A(leaf[2*g]), .B(leaf[2*g+1])
      );
   end

   if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (rst) q[k] <= '0;
            else     q[k] <= leaf[k];
         end
      end
   end else begin : g_comb
      // clk and rst have no role in the combinational variant.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      for (genvar k = 0; k < NUM_OUT; k++) begin : g_pass
         assign q[k] = leaf[k];
      end
   end

   assign A = q[OUT_A];
   assign B = q[OUT_B];
   assign C = q[OUT_C];
   assign D = q[OUT_D];
   assign E = q[OUT_E];
   assign F = q[OUT_F];
   assign G = q[OUT_G];
   assign H = q[OUT_H];
endmodule

// File: tb/tb_demux_1x8.sv
// Bench for demux_1x8: a 1-bit registered, an 8-bit registered and an 8-bit
// combinational instance share stimulus and are checked against a routing model.
module tb_demux_1x8;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [2:0] s   = 3'd0;
   logic       i1  = 1'b0;
   logic [7:0] i8  = 8'h00;

   logic       a1, b1, c1, d1, e1, f1, g1, h1;
   logic [7:0] a8, b8, c8, d8, e8, f8, g8, h8;
   logic [7:0] ac, bc, cc, dc, ec, fc, gc, hc;

   int total = 0;
   int bad   = 0;

   logic [7:0]  exp1_q [$];
   logic [63:0] exp8_q [$];

   always #5 clk = ~clk;

   demux_1x8 #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .I(i1), .S(s),
      .A(a1), .B(b1), .C(c1), .D(d1), .E(e1), .F(f1), .G(g1), .H(h1)
   );

   demux_1x8 #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (
      .clk(clk), .rst(rst), .en(en), .I(i8), .S(s),
      .A(a8), .B(b8), .C(c8), .D(d8), .E(e8), .F(f8), .G(g8), .H(h8)
   );

   demux_1x8 #(.WIDTH(8), .REG_OUT(1'b0)) dutc (
      .clk(clk), .rst(rst), .en(en), .I(i8), .S(s),
      .A(ac), .B(bc), .C(cc), .D(dc), .E(ec), .F(fc), .G(gc), .H(hc)
   );

   // Reference routing: output k carries the data only when enabled and k equals the select.
   function automatic logic [7:0] route1(input logic e, input logic d, input logic [2:0] sel);
      logic [7:0] r;
      r = '0;
      if (e) r[sel] = d;
      return r;
   endfunction

   function automatic logic [63:0] route8(input logic e, input logic [7:0] d, input logic [2:0] sel);
      logic [63:0] r;
      r = '0;
      if (e) r[int'(sel)*8 +: 8] = d;
      return r;
   endfunction

   task automatic check1(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic check8(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, check the combinational instance before the edge
   // and the registered instances one edge later.
   task automatic step(input string tag, input logic r, input logic e, input logic [2:0] sel,
                       input logic d, input logic [7:0] dw);
      logic [7:0]  exp1;
      logic [63:0] exp8;
      rst = r; en = e; s = sel; i1 = d; i8 = dw;
      #1;
      check8({tag, "/comb8"}, {hc, gc, fc, ec, dc, cc, bc, ac}, route8(e, dw, sel));
      exp1_q.push_back(r ? 8'h00 : route1(e, d, sel));
      exp8_q.push_back(r ? 64'h0 : route8(e, dw, sel));
      @(posedge clk);
      #1;
      exp1 = exp1_q.pop_front();
      exp8 = exp8_q.pop_front();
      check1({tag, "/reg1"}, {h1, g1, f1, e1, d1, c1, b1, a1}, exp1);
      check8({tag, "/reg8"}, {h8, g8, f8, e8, d8, c8, b8, a8}, exp8);
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset held for two edges, then released with D selected.
      step("reset0", 1'b1, 1'b1, 3'd3, 1'b1, 8'h3C);
      step("reset1", 1'b1, 1'b1, 3'd3, 1'b1, 8'h3C);
      step("release", 1'b0, 1'b1, 3'd3, 1'b1, 8'h3C);

      for (int k = 0; k < 8; k++)
         step("sweep", 1'b0, 1'b1, 3'(k), 1'b1, 8'($urandom_range(1, 255)));

      for (int k = 0; k < 8; k++)
         step("data_zero", 1'b0, 1'b1, 3'(k), 1'b0, 8'h00);

      step("en_hi0", 1'b0, 1'b1, 3'd5, 1'b1, 8'h5A);
      step("en_lo",  1'b0, 1'b0, 3'd5, 1'b1, 8'h5A);
      step("en_hi1", 1'b0, 1'b1, 3'd5, 1'b1, 8'h5A);

      for (int k = 0; k < 8; k++)
         step("mid_reset", (k == 4), 1'b1, 3'(k), 1'b1, 8'($urandom_range(1, 255)));

      step("wide_a5", 1'b0, 1'b1, 3'd6, 1'b1, 8'hA5);

      for (int n = 0; n < 300; n++)
         step("random", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
              3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
